servo_pwm_ctrl: RTL and testbench

- Avalon-MM slave that drives one hobby servo from an 8-bit position value.
- Generates a fixed-period PWM frame whose pulse width is linear in position.
- Limits slew rate by moving the current position toward the target once per frame.
- Sits on the HPS/Nios lightweight bus alongside the servo PIOs. Raises a move-complete interrupt.

---
 rtl/servo_pwm_ctrl.sv | 157 +++++++++++++++
 tb/tb_servo_pwm_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_ctrl.sv
// Avalon-MM servo controller: fixed-period PWM frame, pulse width linear in position,
// per-frame slew limiting toward the target and a move-complete interrupt.
module servo_pwm_ctrl #(
    parameter int unsigned PERIOD_CYCLES = 1000000,
    parameter int unsigned MIN_PULSE     = 50000,
    parameter int unsigned STEP_CYCLES   = 196,
    parameter int unsigned RESET_POS     = 128
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    output logic        pwm_out,
    output logic        irq
);

    localparam int unsigned   CW   = $clog2(PERIOD_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(PERIOD_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_OFF,
        ST_RUN,
        ST_STOPPING
    } state_t;

    state_t        r_state;
    logic [CW-1:0] r_counter;
    logic [7:0]    r_target;
    logic [7:0]    r_current;
    logic          r_enable;
    logic          r_irq_en;
    logic [7:0]    r_slew;
    logic          r_done;
    logic [31:0]   r_pw;
    logic          r_pwm;
    logic          r_irq;

    logic          w_wr;
    logic          w_wr_target;
    logic          w_wr_ctrl;
    logic          w_wr_status;
    logic          w_active;
    logic          w_wrap;
    logic          w_frame_start;
    logic          w_slew_tick;
    logic          w_set_done;
    logic [31:0]   w_pw;
    logic [31:0]   w_pw_eff;
    logic [7:0]    w_diff;
    logic [7:0]    w_next_pos;
    logic          w_unused;

    assign w_wr          = chipselect & ~write_n;
    assign w_wr_target   = w_wr && (address == 2'd0);
    assign w_wr_ctrl     = w_wr && (address == 2'd1);
    assign w_wr_status   = w_wr && (address == 2'd2);
    assign w_active      = (r_state != ST_OFF);
    assign w_wrap        = (r_counter == LAST);
    assign w_frame_start = w_active && (r_counter == '0);
    assign w_slew_tick   = w_active && w_wrap;
    assign w_unused      = ^writedata[31:16];

    assign w_pw = 32'(MIN_PULSE) + 32'(r_current) * 32'(STEP_CYCLES);
    // The compare on the frame-start cycle must already see the width being latched,
    // otherwise the first cycle of every frame would use the previous frame's width.
    assign w_pw_eff = w_frame_start ? w_pw : r_pw;

    always_comb begin
        w_diff     = (r_target > r_current) ? (r_target - r_current) : (r_current - r_target);
        w_next_pos = r_target;
        if (r_slew != '0 && r_slew < w_diff) begin
            w_next_pos = (r_target > r_current) ? (r_current + r_slew) : (r_current - r_slew);
        end
    end

    assign w_set_done = w_slew_tick && (r_current != r_target) && (w_next_pos == r_target);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_OFF;
            r_counter <= '0;
            r_target  <= 8'(RESET_POS);
            r_current <= 8'(RESET_POS);
            r_enable  <= 1'b0;
            r_irq_en  <= 1'b0;
            r_slew    <= '0;
            r_done    <= 1'b0;
            r_pw      <= '0;
            r_pwm     <= 1'b0;
            r_irq     <= 1'b0;
        end else begin
            r_pwm <= w_active && (32'(r_counter) < w_pw_eff);
            r_irq <= r_done & r_irq_en;

            if (w_frame_start) r_pw <= w_pw;
            if (w_wr_target)   r_target <= writedata[7:0];
            if (w_wr_ctrl) begin
                r_enable <= writedata[0];
                r_irq_en <= writedata[1];
                r_slew   <= writedata[15:8];
            end
            if (w_slew_tick) r_current <= w_next_pos;

            // A completing move outranks a simultaneous write-1-to-clear.
            if (w_set_done) begin
                r_done <= 1'b1;
            end else if (w_wr_status && writedata[1]) begin
                r_done <= 1'b0;
            end

            case (r_state)
                ST_OFF: begin
                    r_counter <= '0;
                    if (w_wr_ctrl && writedata[0]) r_state <= ST_RUN;
                end
                ST_RUN: begin
                    r_counter <= w_wrap ? '0 : r_counter + CW'(1);
                    if (w_wr_ctrl && !writedata[0]) r_state <= ST_STOPPING;
                end
                ST_STOPPING: begin
                    r_counter <= w_wrap ? '0 : r_counter + CW'(1);
                    if (w_wr_ctrl && writedata[0]) begin
                        r_state <= ST_RUN;
                    end else if (w_wrap) begin
                        r_state <= ST_OFF;
                    end
                end
                default: r_state <= ST_OFF;
            endcase
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            2'd0: readdata[7:0] = r_target;
            2'd1: begin
                readdata[0]    = r_enable;
                readdata[1]    = r_irq_en;
                readdata[15:8] = r_slew;
            end
            2'd2: begin
                readdata[0]    = (r_current != r_target);
                readdata[1]    = r_done;
                readdata[15:8] = r_current;
            end
            default: readdata[CW-1:0] = r_counter;
        endcase
    end

    assign pwm_out = r_pwm;
    assign irq     = r_irq;

endmodule

// File: tb/tb_servo_pwm_ctrl.sv
// Scoreboard bench for servo_pwm_ctrl: stimulus queues expected register reads, levels,
// pulse widths and frame gaps; a monitor measures pwm_out and compares at each negedge.
module tb_servo_pwm_ctrl;

    localparam int unsigned PER  = 1000;
    localparam int unsigned MINP = 50;
    localparam int unsigned STEP = 1;

    logic        clk        = 1'b0;
    logic        reset_n    = 1'b0;
    logic [1:0]  address    = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n    = 1'b1;
    logic [31:0] writedata  = '0;
    logic [31:0] readdata;
    logic        pwm_out;
    logic        irq;

    always #5 clk = ~clk;

    servo_pwm_ctrl #(
        .PERIOD_CYCLES(PER),
        .MIN_PULSE    (MINP),
        .STEP_CYCLES  (STEP),
        .RESET_POS    (128)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .pwm_out   (pwm_out),
        .irq       (irq)
    );

    typedef enum int {K_RD, K_PWM, K_IRQ, K_GAP} kind_t;

    kind_t       kq[$];
    logic [31:0] eq[$];
    string       nq[$];
    int unsigned pq[$];

    int          checks = 0;
    int          errors = 0;
    logic        smp_req  = 1'b0;
    logic        smp_kick = 1'b0;
    int unsigned cyc = 0;
    int unsigned hi = 0;
    int unsigned last_rise = 0;
    int unsigned last_gap = 0;
    logic        prev = 1'b0;

    task automatic drain();
        kind_t       k;
        logic [31:0] e;
        logic [31:0] a;
        string       n;
        while (kq.size() > 0) begin
            k = kq.pop_front();
            e = eq.pop_front();
            n = nq.pop_front();
            case (k)
                K_RD:    a = readdata;
                K_PWM:   a = {31'b0, pwm_out};
                K_IRQ:   a = {31'b0, irq};
                default: a = last_gap;
            endcase
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got 0x%0h, expected 0x%0h", n, a, e);
            end
        end
    endtask

    // Monitor: pulse widths and rise-to-rise gaps, plus queued samples on request.
    initial forever begin
        int unsigned exp_w;
        @(negedge clk);
        cyc++;
        if (!reset_n) begin
            hi   = 0;
            prev = 1'b0;
        end else begin
            if (pwm_out) begin
                if (!prev) begin
                    last_gap  = cyc - last_rise;
                    last_rise = cyc;
                end
                hi++;
            end else if (prev) begin
                checks++;
                if (pq.size() == 0) begin
                    errors++;
                    $display("FAIL pulse_unexpected: got %0d-cycle pulse, expected none", hi);
                end else begin
                    exp_w = pq.pop_front();
                    if (hi != exp_w) begin
                        errors++;
                        $display("FAIL pulse_width: got %0d cycles, expected %0d", hi, exp_w);
                    end
                end
                hi = 0;
            end
            prev = pwm_out;
        end
        if (smp_req) drain();
    end

    initial forever begin
        @(smp_kick);
        drain();
    end

    task automatic push(kind_t k, logic [31:0] e, string n);
        kq.push_back(k);
        eq.push_back(e);
        nq.push_back(n);
    endtask

    task automatic sample();
        smp_req = 1'b1;
        @(negedge clk);
        #1;
        smp_req = 1'b0;
    endtask

    task automatic exp_rd(logic [1:0] a, logic [31:0] e, string n);
        address = a;
        push(K_RD, e, n);
        sample();
    endtask

    task automatic kick();
        smp_kick = ~smp_kick;
        #1;
    endtask

    task automatic idle(int unsigned n);
        repeat (n) @(negedge clk);
        #1;
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic poll(logic [31:0] v, string n);
        bit found;
        found   = 1'b0;
        address = 2'd3;
        for (int unsigned i = 0; i < 2100; i++) begin
            @(negedge clk);
            if (readdata == v) begin
                found = 1'b1;
                break;
            end
        end
        #1;
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL %s: frame counter never reached %0d, expected it within 2100 cycles", n, v);
        end
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time exhausted, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        idle(3);
        reset_n = 1'b1;
        push(K_PWM, 0, "rst_pwm");
        push(K_IRQ, 0, "rst_irq");
        exp_rd(2'd0, 32'h80, "rst_target");
        exp_rd(2'd1, 32'h0, "rst_control");
        exp_rd(2'd2, 32'h8000, "rst_status");
        exp_rd(2'd3, 32'h0, "rst_frame");

        // Basic PWM at position 128: 50 + 128 = 178 cycles
        pq.push_back(178);
        pq.push_back(178);
        wr(2'd1, 32'h1);
        push(K_PWM, 0, "first_frame_pwm_low");
        exp_rd(2'd3, 32'h0, "first_frame_counter0");
        push(K_PWM, 1, "first_rise");
        sample();
        poll(0, "f2_start");
        push(K_GAP, PER, "frame_period");
        sample();

        // Immediate jump with slew 0
        poll(500, "f2_mid");
        wr(2'd0, 32'd100);
        pq.push_back(150);
        exp_rd(2'd0, 32'h64, "target_100");
        exp_rd(2'd2, 32'h8001, "jump_busy");
        poll(0, "f3_start");
        push(K_IRQ, 0, "jump_irq_masked");
        exp_rd(2'd2, 32'h6402, "jump_done");

        // Slew 10 from 0 to 35 with interrupt
        poll(100, "f3_mid");
        wr(2'd0, 32'd0);
        pq.push_back(50);
        poll(0, "f4_start");
        exp_rd(2'd2, 32'h0002, "at_zero");
        wr(2'd2, 32'h2);
        wr(2'd1, 32'h0A03);
        wr(2'd0, 32'd35);
        exp_rd(2'd1, 32'h0A03, "control_slew");
        push(K_IRQ, 0, "slew_irq_idle");
        exp_rd(2'd2, 32'h0001, "slew_busy0");
        pq.push_back(60);
        pq.push_back(70);
        pq.push_back(80);
        pq.push_back(85);
        poll(0, "f5_start");
        exp_rd(2'd2, 32'h0A01, "slew_pos10");
        poll(0, "f6_start");
        poll(0, "f7_start");
        exp_rd(2'd2, 32'h1E01, "slew_pos30");
        poll(999, "f7_end");
        push(K_IRQ, 0, "irq_lags_done");
        exp_rd(2'd2, 32'h2302, "slew_done");
        push(K_IRQ, 1, "irq_set");
        sample();
        wr(2'd2, 32'h2);
        push(K_IRQ, 1, "irq_before_clear");
        exp_rd(2'd2, 32'h2300, "done_cleared");
        push(K_IRQ, 0, "irq_cleared");
        sample();

        // Clean stop at counter 20 while pw = 150
        wr(2'd1, 32'h1);
        wr(2'd0, 32'd100);
        pq.push_back(150);
        poll(0, "f9_start");
        poll(20, "f9_c20");
        wr(2'd1, 32'h0);
        exp_rd(2'd1, 32'h0, "control_off");
        poll(999, "f9_end");
        push(K_PWM, 0, "stopped_pwm");
        exp_rd(2'd3, 32'h0, "stopped_frame");
        idle(5);
        push(K_PWM, 0, "off_pwm");
        exp_rd(2'd3, 32'h0, "off_frame_held");

        // Re-enable during STOPPING: no frame gap
        pq.push_back(150);
        pq.push_back(150);
        wr(2'd1, 32'h1);
        poll(20, "f10_c20");
        wr(2'd1, 32'h0);
        poll(600, "f10_c600");
        wr(2'd1, 32'h1);
        poll(0, "f11_start");
        push(K_GAP, PER, "reenable_no_gap");
        sample();

        // Full-scale position: 50 + 255 = 305
        wr(2'd0, 32'd255);
        pq.push_back(305);
        poll(0, "f12_start");
        exp_rd(2'd2, 32'hFF02, "pos255");

        // Slew 200 from 255 toward 0: 55 then 0
        wr(2'd2, 32'h2);
        wr(2'd1, 32'hC801);
        wr(2'd0, 32'd0);
        pq.push_back(105);
        pq.push_back(50);
        poll(0, "f13_start");
        exp_rd(2'd2, 32'h3701, "slew200_pos55");
        poll(0, "f14_start");
        exp_rd(2'd2, 32'h0002, "slew200_pos0");

        // W1C landing on the wrap cycle where done sets
        wr(2'd1, 32'h1);
        wr(2'd2, 32'h2);
        wr(2'd0, 32'd20);
        exp_rd(2'd2, 32'h0001, "pre_wrap_status");
        pq.push_back(70);
        poll(999, "f14_end");
        wr(2'd2, 32'h2);
        exp_rd(2'd2, 32'h1402, "done_set_wins");

        // TARGET write landing on the wrap cycle uses old target
        pq.push_back(70);
        poll(999, "f15_end");
        wr(2'd0, 32'd40);
        exp_rd(2'd2, 32'h1403, "old_target_used");
        exp_rd(2'd0, 32'h28, "new_target_held");
        wr(2'd1, 32'h3);
        poll(0, "f17_start");
        push(K_IRQ, 1, "irq_before_reset");
        exp_rd(2'd2, 32'h2802, "new_target_applied");

        // Asynchronous reset mid-pulse
        poll(40, "f17_c40");
        push(K_PWM, 1, "pwm_high_before_reset");
        push(K_IRQ, 1, "irq_high_before_reset");
        kick();
        reset_n = 1'b0;
        #1;
        push(K_PWM, 0, "reset_pwm_async");
        push(K_IRQ, 0, "reset_irq_async");
        kick();
        exp_rd(2'd0, 32'h80, "reset_target");
        exp_rd(2'd1, 32'h0, "reset_control");
        exp_rd(2'd2, 32'h8000, "reset_status");
        exp_rd(2'd3, 32'h0, "reset_frame");
        reset_n = 1'b1;
        idle(3);
        push(K_PWM, 0, "post_reset_pwm");
        push(K_IRQ, 0, "post_reset_irq");
        exp_rd(2'd2, 32'h8000, "post_reset_status");
        exp_rd(2'd3, 32'h0, "post_reset_frame");

        checks++;
        if (pq.size() != 0) begin
            errors++;
            $display("FAIL pulses_outstanding: got %0d unseen pulses, expected 0", pq.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
